// File: rtl/factorio_param.sv
// Iterative N! unit: one multiply per cycle, width-generic, overflow -> ERR.
// Define FACTORIO_ABORT_EN to add the Abort input, which cancels LOAD/MULT back to IDLE.
module factorio_param #(
    parameter int unsigned N_W   = 4,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Go,
    input  logic [N_W-1:0]   N,
`ifdef FACTORIO_ABORT_EN
    input  logic             Abort,
`endif
    output logic [OUT_W-1:0] Out,
    output logic             Done,
    output logic             Error,
    output logic             Busy,
    output logic [2:0]       CS
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MULT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [N_W-1:0]     cnt_q, cnt_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [2*OUT_W-1:0] prod;

    // Full-width product; any bit above OUT_W means the result no longer fits.
    assign prod = (2*OUT_W)'(acc_q) * (2*OUT_W)'(cnt_q);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        out_d   = out_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (Go) begin
                    n_d     = N;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                acc_d   = OUT_W'(1);
                cnt_d   = n_q;
                state_d = MULT;
            end
            MULT: begin
                if (cnt_q <= N_W'(1)) begin
                    out_d   = acc_q;
                    state_d = DONE;
                end else if (|prod[2*OUT_W-1:OUT_W]) begin
                    state_d = ERR;
                end else begin
                    acc_d = prod[OUT_W-1:0];
                    cnt_d = cnt_q - N_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef FACTORIO_ABORT_EN
        // Abort overrides everything computed above for LOAD/MULT, including a final Out update.
        if (Abort && (state_q == LOAD || state_q == MULT)) begin
            state_d = IDLE;
            acc_d   = acc_q;
            cnt_d   = cnt_q;
            out_d   = out_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            out_q   <= out_d;
        end
    end

    assign Out   = out_q;
    assign Done  = (state_q == DONE);
    assign Error = (state_q == ERR);
    assign Busy  = (state_q == LOAD) || (state_q == MULT);
    assign CS    = state_q;

endmodule

// File: tb/tb_factorio_param.sv
// Directed scoreboard bench for factorio_param: a default 4/32 instance and a 5/64 instance.
module tb_factorio_param;

    logic        clk;
    logic        rst_n;
    logic        go_a, go_b;
    logic [3:0]  n_a;
    logic [4:0]  n_b;
    logic        abort_a, abort_b;
    logic [31:0] out_a;
    logic [63:0] out_b;
    logic        done_a, err_a, busy_a, done_b, err_b, busy_b;
    logic [2:0]  cs_a, cs_b;

    int vectors;
    int miscompares;

    typedef struct {
        logic [63:0] out;
        logic        err;
        int          lat;
        int          busy;
    } exp_t;
    exp_t sb[$];

    factorio_param dut_a (
        .clk(clk), .reset(rst_n), .Go(go_a), .N(n_a),
`ifdef FACTORIO_ABORT_EN
        .Abort(abort_a),
`endif
        .Out(out_a), .Done(done_a), .Error(err_a), .Busy(busy_a), .CS(cs_a)
    );

    factorio_param #(.N_W(5), .OUT_W(64)) dut_b (
        .clk(clk), .reset(rst_n), .Go(go_b), .N(n_b),
`ifdef FACTORIO_ABORT_EN
        .Abort(abort_b),
`endif
        .Out(out_b), .Done(done_b), .Error(err_b), .Busy(busy_b), .CS(cs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] o_out(input bit s);
        return s ? out_b : {32'd0, out_a};
    endfunction
    function automatic logic o_done(input bit s);
        return s ? done_b : done_a;
    endfunction
    function automatic logic o_err(input bit s);
        return s ? err_b : err_a;
    endfunction
    function automatic logic o_busy(input bit s);
        return s ? busy_b : busy_a;
    endfunction
    function automatic logic [2:0] o_cs(input bit s);
        return s ? cs_b : cs_a;
    endfunction

    // Called at a negedge; pulses Go for one cycle, optionally re-pulses Go at edge toggle_at.
    task automatic run_job(input bit sel, input logic [4:0] n, input logic [63:0] exp_out,
                           input logic exp_err, input int exp_lat, input int exp_busy,
                           input int toggle_at);
        exp_t e;
        int   edges;
        int   busy_cnt;
        bit   seen;
        e.out = exp_out; e.err = exp_err; e.lat = exp_lat; e.busy = exp_busy;
        sb.push_back(e);
        if (sel) begin go_b = 1'b1; n_b = n; end
        else     begin go_a = 1'b1; n_a = n[3:0]; end
        edges = 0; busy_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            go_a = 1'b0; go_b = 1'b0;
            if (toggle_at != 0 && edges == toggle_at) begin
                if (sel) begin go_b = 1'b1; n_b = 5'd9; end
                else     begin go_a = 1'b1; n_a = 4'd9; end
            end
            if (o_busy(sel)) busy_cnt++;
            if (o_done(sel) || o_err(sel)) seen = 1'b1;
        end
        go_a = 1'b0; go_b = 1'b0;
        e = sb.pop_front();
        check("result_seen", 64'(seen), 64'd1);
        check("latency", 64'(edges), 64'(e.lat));
        check("busy_cycles", 64'(busy_cnt), 64'(e.busy));
        check("error_flag", 64'(o_err(sel)), 64'(e.err));
        check("done_flag", 64'(o_done(sel)), 64'(!e.err));
        check("cs", 64'(o_cs(sel)), e.err ? 64'd4 : 64'd3);
        check("out", o_out(sel), e.out);
    endtask

    initial begin
        int prev_done;
        int last;
        int pulses;
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; go_a = 1'b0; go_b = 1'b0; n_a = '0; n_b = '0;
        abort_a = 1'b0; abort_b = 1'b0;
        #12;
        check("rst_cs", 64'(cs_a), 64'd0);
        check("rst_out", o_out(0), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_err", 64'(err_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(0, 5'd5, 64'd120, 1'b0, 7, 6, 0);
        run_job(0, 5'd0, 64'd1, 1'b0, 3, 2, 0);

        // Async reset in the third MULT cycle of 9!
        go_a = 1'b1; n_a = 4'd9;
        @(posedge clk);
        @(negedge clk);
        go_a = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_cs", 64'(cs_a), 64'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_cs", 64'(cs_a), 64'd0);
        check("midrst_out", o_out(0), 64'd0);
        check("midrst_done", 64'(done_a), 64'd0);
        check("midrst_err", 64'(err_a), 64'd0);
        check("midrst_busy", 64'(busy_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 64'(cs_a), 64'd0);
        check("post_rst_busy", 64'(busy_a), 64'd0);

        run_job(0, 5'd12, 64'h1C8CFC00, 1'b0, 14, 13, 0);
        run_job(0, 5'd13, 64'h1C8CFC00, 1'b1, 14, 13, 0);

        // Go held high: Done must pulse once every five cycles.
        go_a = 1'b1; n_a = 4'd3;
        prev_done = 0; last = 0; pulses = 0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) begin
                pulses++;
                check("held_single", 64'(prev_done), 64'd0);
                check("held_out", o_out(0), 64'd6);
                if (last != 0) check("held_period", 64'(i - last), 64'd5);
                last = i;
            end
            prev_done = int'(done_a);
        end
        go_a = 1'b0;
        check("held_pulses", 64'(pulses), 64'd5);

        run_job(0, 5'd3, 64'd6, 1'b0, 5, 4, 3);
        repeat (3) @(negedge clk);
        check("no_queued_go", 64'(cs_a), 64'd3);

        run_job(1, 5'd20, 64'h21C3677C82B40000, 1'b0, 22, 21, 0);
        run_job(1, 5'd21, 64'h21C3677C82B40000, 1'b1, 21, 20, 0);

`ifdef FACTORIO_ABORT_EN
        go_a = 1'b1; n_a = 4'd10;
        @(posedge clk);
        @(negedge clk);
        go_a = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_abort_cs", 64'(cs_a), 64'd2);
        abort_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort_a = 1'b0;
        check("abort_cs", 64'(cs_a), 64'd0);
        check("abort_done", 64'(done_a), 64'd0);
        check("abort_err", 64'(err_a), 64'd0);
        check("abort_out", o_out(0), 64'd6);
        run_job(0, 5'd4, 64'd24, 1'b0, 6, 5, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/factorio_param.md
Name: factorio_param

Overview:
- Parametrised successor to the fixed 4-bit/32-bit factorial unit.
- Computes N! iteratively, one multiply per cycle, with width-generic datapath and overflow detection in place of a fixed range check.
- Go/Done/Error/state interface, so it drops into the same SoC slot; adds Busy.
- Control unit and datapath are in one module; an optional abort is compiled in by macro.

Parameters:
- N_W, 4, width of operand N.
- OUT_W, 32, width of result Out and of the accumulator.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset=0 resets).
- Go  input  1  start request, level-sampled on clk in IDLE, DONE or ERR.
- N  input  N_W  operand, latched on the edge that accepts Go.
- Out  output  OUT_W  result of last successful computation.
- Done  output  1  high while in DONE.
- Error  output  1  high while in ERR.
- Busy  output  1  high in LOAD and MULT.
- CS  output  3  current state encoding.
- Abort  input  1  present only with FACTORIO_ABORT_EN.

Behaviour:
- Reset (reset=0, async) forces:
  - state=IDLE, CS=3'd0, Out=0, Done=0, Error=0, Busy=0;
  - internal acc=0, cnt=0, N latch=0.
  - Reset mid-computation discards all work.
- State encoding: IDLE=0, LOAD=1, MULT=2, DONE=3, ERR=4; codes 5-7 are illegal and go to IDLE on the next edge.
- IDLE: Go=1 -> LOAD, latching N into an N_W-bit register. Go=0 -> stay.
- LOAD, one cycle: acc=1, cnt=latched N, -> MULT. Go is ignored from here until DONE/ERR.
- MULT, each edge:
  - cnt<=1 -> DONE, Out<=acc.
  - Otherwise, form the 2*OUT_W-bit product p=acc*cnt, with cnt zero-extended to OUT_W.
    - Upper OUT_W bits of p nonzero -> ERR; Out unchanged, acc not updated.
    - Else acc<=p[OUT_W-1:0], cnt<=cnt-1, stay in MULT.
- DONE: Done=1; Out holds. Go=1 -> LOAD (new N latched, Done drops on that edge); Go=0 -> stay.
- ERR: Error=1; Out keeps the previous successful result. Go=1 -> LOAD; Go=0 -> stay.
- Latency, counted from the edge that accepts Go to the edge entering DONE inclusive: N+2 edges for N>=1, 3 edges for N=0.
  - 0! = 1! = 1.
- Error latency: entry to ERR occurs on the first overflowing multiply.
- Go held high continuously restarts after every DONE/ERR. Done is then high for exactly one cycle per result.
- Go pulses during LOAD/MULT have no effect and are not queued.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- cnt is N_W bits wide. With N at its maximum (2^N_W - 1), no wrap occurs because the counter only decrements to 1.

Optional Feature:
- Macro FACTORIO_ABORT_EN.
- When defined:
  - The Abort port exists.
  - Abort=1 sampled in LOAD or MULT -> IDLE on that edge; Out, Done and Error are unchanged (remain 0, since they are low in those states).
  - Abort in IDLE/DONE/ERR is ignored.
  - Abort and Go both high in DONE/ERR: Go wins (-> LOAD).
- When undefined: no Abort port, no abort logic; a computation always runs to DONE or ERR.

Test Plan:
- Reset low mid-MULT (N=9, third MULT cycle) -> immediately CS=0, Out=0, Done=0, Error=0, Busy=0. After release, stays IDLE with Go=0.
- Defaults, N=5, Go one-cycle pulse -> Done rises 7 edges after acceptance, Out=32'd120, Busy high for 6 cycles, Error=0. Then N=0 -> Out=1 after 3 edges.
- Defaults, N=12 -> Out=32'h1C8CFC00, Done=1. Then N=13 -> Error=1, Done=0, Out stays 32'h1C8CFC00.
- N_W=5, OUT_W=64, N=20 -> Out=64'h21C3677C82B40000, Done=1. Then N=21 -> Error=1.
- Go held high with N=3 -> repeated LOAD/MULT/DONE cycles, Done a single-cycle pulse each 5 cycles, Out=6. Go toggled during MULT -> no restart.
- FACTORIO_ABORT_EN, N=10, Abort=1 on 4th MULT cycle -> CS=0 next edge, Done=0, Error=0, Out unchanged. Then Go with N=4 -> Out=24.
